// File: rtl/fetcher_if.sv
// Fetcher bus bundle: memory-controller request/response, decoder issue port
// and ROB/back-pressure inputs. The fetcher side uses the master modport.
interface fetcher_if;
    logic        mc_request_out;
    logic [31:0] mc_addr_out;
    logic        mc_ready_in;
    logic [31:0] mc_data_in;

    logic        dec_issue_out;
    logic [31:0] dec_inst_out;
    logic [31:0] dec_pc_out;
    logic [31:0] dec_predict_pc_out;

    logic        full_in;
    logic        rob_flush_in;
    logic [31:0] rob_target_pc_in;

    modport master (
        output mc_request_out,
        output mc_addr_out,
        input  mc_ready_in,
        input  mc_data_in,
        output dec_issue_out,
        output dec_inst_out,
        output dec_pc_out,
        output dec_predict_pc_out,
        input  full_in,
        input  rob_flush_in,
        input  rob_target_pc_in
    );

    modport slave (
        input  mc_request_out,
        input  mc_addr_out,
        output mc_ready_in,
        output mc_data_in,
        input  dec_issue_out,
        input  dec_inst_out,
        input  dec_pc_out,
        input  dec_predict_pc_out,
        output full_in,
        output rob_flush_in,
        output rob_target_pc_in
    );
endinterface

// File: rtl/fetcher.sv
// Instruction fetcher: one outstanding word fetch, static branch prediction,
// 4-entry instruction queue feeding the decoder, flush-and-redirect from the ROB.
module fetcher (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    fetcher_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam int DEPTH = 4;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [2:0]  count, count_nxt;
    logic [1:0]  head, head_nxt;
    logic [1:0]  tail, tail_nxt;
    logic        req, req_nxt;
    logic [31:0] addr, addr_nxt;

    logic [31:0] inst_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] pred_q [DEPTH];

    logic        push;
    logic        issue;
    logic [31:0] pred_pc;

    // Static prediction: JAL always taken, backward conditional branches taken,
    // everything else (JALR included) falls through.
    function automatic logic [31:0] predict_next(input logic [31:0] cur_pc,
                                                 input logic [31:0] inst);
        logic signed [31:0] imm_j;
        logic signed [31:0] imm_b;
        logic [31:0]        next_pc;
        imm_j   = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_b   = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        next_pc = cur_pc + 32'd4;
        if (inst[6:0] == 7'b1101111) begin
            next_pc = cur_pc + imm_j;
        end else if (inst[6:0] == 7'b1100011 && inst[31]) begin
            next_pc = cur_pc + imm_b;
        end
        return next_pc;
    endfunction

    assign pred_pc = predict_next(pc, bus.mc_data_in);

    assign issue = rdy_in && !rst_in && (count != 3'd0) && !bus.full_in && !bus.rob_flush_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            pc    <= '0;
            count <= '0;
            head  <= '0;
            tail  <= '0;
            req   <= 1'b0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            count <= count_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
            req   <= req_nxt;
            addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        count_nxt = count;
        head_nxt  = head;
        tail_nxt  = tail;
        req_nxt   = req;
        addr_nxt  = addr;
        push      = 1'b0;

        if (rdy_in) begin
            if (bus.rob_flush_in) begin
                // Redirect wins over everything; a response still in flight
                // must be swallowed in DISCARD.
                count_nxt = '0;
                head_nxt  = '0;
                tail_nxt  = '0;
                pc_nxt    = bus.rob_target_pc_in;
                req_nxt   = 1'b0;
                case (state)
                    WAIT:    state_nxt = bus.mc_ready_in ? IDLE : DISCARD;
                    DISCARD: state_nxt = bus.mc_ready_in ? IDLE : DISCARD;
                    default: state_nxt = IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (count < 3'd4) begin
                            req_nxt   = 1'b1;
                            addr_nxt  = pc;
                            state_nxt = WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.mc_ready_in) begin
                            push      = 1'b1;
                            pc_nxt    = pred_pc;
                            req_nxt   = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                    DISCARD: begin
                        if (bus.mc_ready_in) begin
                            state_nxt = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase

                if (push) begin
                    tail_nxt = tail + 2'd1;
                end
                if (issue) begin
                    head_nxt = head + 2'd1;
                end
                count_nxt = count + {2'b00, push} - {2'b00, issue};
            end
        end
    end

    // Queue payload carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_q[tail] <= bus.mc_data_in;
            pc_q[tail]   <= pc;
            pred_q[tail] <= pred_pc;
        end
    end

    assign bus.mc_request_out     = req;
    assign bus.mc_addr_out        = addr;
    assign bus.dec_issue_out      = issue;
    assign bus.dec_inst_out       = issue ? inst_q[head] : '0;
    assign bus.dec_pc_out         = issue ? pc_q[head]   : '0;
    assign bus.dec_predict_pc_out = issue ? pred_q[head] : '0;

endmodule

// File: tb/tb_fetcher.sv
// Randomized bench for fetcher: directed scenarios then random traffic, all
// checked against a queue-based behavioural model of the fetch unit.
module tb_fetcher;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    fetcher_if bus();

    fetcher dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Prediction computed from immediate field weights.
    function automatic logic [31:0] model_predict(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] off;
        if (w[6:0] == 7'b1101111) begin
            off = 32'(w[30:21]) * 2 + 32'(w[20]) * 2048 + 32'(w[19:12]) * 4096
                  - 32'(w[31]) * 32'h0010_0000;
            return pc + off;
        end
        if (w[6:0] == 7'b1100011 && w[31]) begin
            off = 32'(w[11:8]) * 2 + 32'(w[30:25]) * 32 + 32'(w[7]) * 2048
                  - 32'(w[31]) * 4096;
            return pc + off;
        end
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] enc_jal(input int off);
        logic [20:0] o;
        o = 21'(off);
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input int off);
        logic [12:0] o;
        o = 13'(off);
        return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_addi(input int k);
        return {12'(k), 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        case ($urandom_range(0, 4))
            0: w = enc_addi(int'($urandom_range(0, 4095)));
            1: w = enc_jal(int'($urandom_range(0, 8190)) - 4096);
            2: w = enc_br(int'($urandom_range(0, 8190)) - 4096);
            3: begin
                w = $urandom;
                w[6:0] = 7'b1100111;
            end
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic model_step(input bit r, input bit rd, input bit fl, input logic [31:0] tgt,
                              input bit mr, input logic [31:0] md, input bit fu);
        int          size0;
        logic [31:0] p;
        if (r) begin
            mq.delete();
            m_pc   = '0;
            m_addr = '0;
            m_out  = 0;
            m_drop = 0;
            return;
        end
        if (!rd) return;
        if (fl) begin
            mq.delete();
            m_pc = tgt;
            if (m_out) begin
                if (mr) begin
                    m_out  = 0;
                    m_drop = 0;
                end else begin
                    m_drop = 1;
                end
            end
            return;
        end
        size0 = mq.size();
        if (size0 > 0 && !fu) void'(mq.pop_front());
        if (m_out) begin
            if (mr) begin
                if (!m_drop) begin
                    p = model_predict(m_pc, md);
                    mq.push_back('{inst: md, pc: m_pc, pred: p});
                    m_pc = p;
                end
                m_out  = 0;
                m_drop = 0;
            end
        end else if (size0 < 4) begin
            m_out  = 1;
            m_addr = m_pc;
        end
    endtask

    task automatic step(input bit r, input bit rd, input bit fl, input logic [31:0] tgt,
                        input bit mr, input logic [31:0] md, input bit fu);
        bit   ei;
        ent_t e;
        rst_in               = r;
        rdy_in               = rd;
        bus.rob_flush_in     = fl;
        bus.rob_target_pc_in = tgt;
        bus.mc_ready_in      = mr;
        bus.mc_data_in       = md;
        bus.full_in          = fu;
        #1;
        check("mc_request", 32'(bus.mc_request_out), 32'(m_out && !m_drop));
        check("mc_addr", bus.mc_addr_out, m_addr);
        ei = !r && rd && !fl && !fu && (mq.size() > 0);
        e  = '0;
        if (ei) e = mq[0];
        check("dec_issue", 32'(bus.dec_issue_out), 32'(ei));
        check("dec_inst", bus.dec_inst_out, e.inst);
        check("dec_pc", bus.dec_pc_out, e.pc);
        check("dec_predict_pc", bus.dec_predict_pc_out, e.pred);
        model_step(r, rd, fl, tgt, mr, md, fu);
        @(posedge clk_in);
        #1;
    endtask

    task automatic serve(input int n, input bit fu, input logic [31:0] w);
        repeat (n) step(1'b0, 1'b1, 1'b0, '0, m_out && !m_drop, w, fu);
    endtask

    task automatic flush_to(input logic [31:0] tgt);
        step(1'b0, 1'b1, 1'b1, tgt, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int full_pct;
        rst_in               = 1'b1;
        rdy_in               = 1'b1;
        bus.rob_flush_in     = 1'b0;
        bus.rob_target_pc_in = '0;
        bus.mc_ready_in      = 1'b0;
        bus.mc_data_in       = '0;
        bus.full_in          = 1'b0;
        model_step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk_in);
        #1;

        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 32'h6f, 1'b0);

        // sequential ADDI stream with single-cycle memory
        serve(12, 1'b0, enc_addi(5));

        // back-pressure fills the queue, then drains and fetch resumes
        serve(24, 1'b1, enc_addi(7));
        serve(12, 1'b0, enc_addi(9));

        // prediction cases
        flush_to(32'h10);
        serve(4, 1'b0, enc_jal(8));
        flush_to(32'h20);
        serve(4, 1'b0, enc_br(-4));
        flush_to(32'h30);
        serve(4, 1'b0, enc_br(12));
        flush_to(32'h0);
        serve(4, 1'b0, enc_br(-8));

        // flush while a fetch is pending, response arrives two cycles later
        flush_to(32'h40);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        flush_to(32'h100);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, enc_addi(3), 1'b0);
        serve(6, 1'b0, enc_addi(4));

        // flush coincident with the response
        flush_to(32'h180);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h1c0, 1'b1, enc_addi(1), 1'b0);
        serve(4, 1'b0, enc_addi(2));

        // reset while waiting, late response must be ignored
        flush_to(32'h200);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, enc_addi(6), 1'b0);
        serve(6, 1'b0, enc_addi(8));

        // global stall freezes a pending fetch and a non-empty queue
        serve(5, 1'b1, enc_addi(11));
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, enc_jal(16), 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, enc_jal(16), 1'b0);
        serve(10, 1'b0, enc_addi(12));

        full_pct = 30;
        for (int i = 0; i < 4000; i++) begin
            bit r, rd, fl, mr, fu;
            if (i % 250 == 0) full_pct = int'($urandom_range(0, 90));
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 99) < 90);
            fl = ($urandom_range(0, 99) < 5);
            mr = (m_out) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
            fu = ($urandom_range(0, 99) < full_pct);
            step(r, rd, fl, $urandom, mr, rand_inst(), fu);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 clk_in  input  1  single clock; all state updates on rising edge.
REQ-002 rst_in  input  1  reset, synchronous, active-high.
REQ-003 rdy_in  input  1  global ready; low freezes all state.
REQ-004 mc_request_out  output  1  instruction word fetch request to memory controller.
REQ-005 mc_addr_out  output  32  byte address of requested word.
REQ-006 mc_ready_in  input  1  one-cycle pulse; mc_data_in valid this cycle.
REQ-007 mc_data_in  input  32  fetched instruction word.
REQ-008 dec_issue_out  output  1  instruction valid to decoder this cycle.
REQ-009 dec_inst_out  output  32  instruction word.
REQ-010 dec_pc_out  output  32  instruction PC.
REQ-011 dec_predict_pc_out  output  32  predicted next PC.
REQ-012 full_in  input  1  downstream (ROB/RS/LSB) full; blocks issue.
REQ-013 rob_flush_in  input  1  misprediction flush, one-cycle pulse.
REQ-014 rob_target_pc_in  input  32  correct PC, valid with rob_flush_in.

Function
REQ-015 Instruction queue SHALL be a 4-entry FIFO of {inst, pc, predict_pc}, 2-bit head/tail pointers with wrap-around, 3-bit count 0..4.
REQ-016 FSM SHALL have states IDLE, WAIT, DISCARD.
REQ-017 IDLE: if count plus 0 < 4 and no flush, assert mc_request_out with mc_addr_out = pc, go to WAIT next cycle.
REQ-018 WAIT: hold mc_request_out high and mc_addr_out stable until mc_ready_in; on mc_ready_in push entry, set pc to predicted PC, return to IDLE.
REQ-019 At most one outstanding request; since requests are issued only when count <= 3, a push SHALL never hit a full queue.
REQ-020 Prediction from mc_data_in: opcode 1101111 (JAL) -> pc + immJ; opcode 1100011 (branch) with immB sign bit 1 -> pc + immB; branch with sign 0 -> pc + 4; all others (incl. JALR) -> pc + 4.
REQ-021 immJ/immB SHALL be sign-extended to 32 bits per RV32I; address adds SHALL wrap modulo 2^32.
REQ-022 dec_issue_out SHALL be combinational: count != 0 and !full_in and !rob_flush_in and rdy_in; dec_* data driven from head entry; head pops on the same edge.
REQ-023 When dec_issue_out is 0, dec_inst_out/pc/predict_pc SHALL be 0.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and both pointers advance.
REQ-025 rob_flush_in SHALL clear the queue (count, head, tail to 0), set pc = rob_target_pc_in, and drop mc_request_out next cycle.
REQ-026 Flush in IDLE -> IDLE; flush in WAIT without mc_ready_in same cycle -> DISCARD; flush with mc_ready_in same cycle -> data dropped, IDLE.
REQ-027 DISCARD: mc_request_out low; on mc_ready_in drop data, go to IDLE; a second flush in DISCARD only updates pc.
REQ-028 Flush SHALL take priority over push, pop and new request in the same cycle.
REQ-029 rdy_in low: no register changes, dec_issue_out 0, mc_request_out/mc_addr_out hold previous values.

Reset
REQ-030 On rst_in high at a clock edge: pc = 0, count/head/tail = 0, state IDLE, mc_request_out 0, mc_addr_out 0, all dec_* outputs 0.
REQ-031 Reset SHALL override rdy_in, flush and mc_ready_in; mid-WAIT reset discards any pending response to IDLE without DISCARD.
REQ-032 First request SHALL appear the cycle after rst_in deasserts, at address 0.

Verification
REQ-033 Sequential: four ADDI words at 0,4,8,12, 1-cycle memory latency, full_in 0 -> issued in order, dec_predict_pc_out = pc+4 each.
REQ-034 Full stall: full_in 1, fetch 5 words -> requests stop after 4 pushes, count 4; release full_in -> 4 issues on 4 consecutive cycles, then fetch resumes at 16.
REQ-035 Prediction: JAL +8 at 0x10 -> predict 0x18, next request 0x18; BEQ -4 at 0x20 -> predict 0x1C; BEQ +12 at 0x30 -> predict 0x34.
REQ-036 Flush in WAIT: request at 0x40 pending, flush to 0x100, mc_ready_in 2 cycles later -> data dropped, queue empty, next request at 0x100.
REQ-037 Simultaneous push/pop at count 2 -> count stays 2, issued order preserved across pointer wrap.
REQ-038 Reset mid-WAIT with pending request -> state IDLE, next request at 0, late mc_ready_in ignored.
